// File: rtl/resync_fifo_nonsynt.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
// Flags are decoded combinationally from the registered pointers.
module resync_fifo_nonsynt #(
  parameter int width     = 20,
  parameter int log_depth = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             val_wr,
  input  logic [width-1:0] data_wr,
  input  logic             val_rd,
  output logic [width-1:0] data_rd,
  output logic             empty_rd,
  output logic             full_wr,
  output logic             almost_empty_rd
);

  localparam int DEPTH = 2 ** log_depth;

  logic [log_depth:0]   wr_ptr;
  logic [log_depth:0]   rd_ptr;
  logic [log_depth:0]   fill;
  logic [width-1:0]     mem [DEPTH];
  logic                 wr_en;
  logic                 rd_en;

  // Accept decisions look only at flags decoded from registered pointers.
  assign wr_en = val_wr & ~full_wr;
  assign rd_en = val_rd & ~empty_rd;

  assign fill            = wr_ptr - rd_ptr;
  assign empty_rd        = (wr_ptr == rd_ptr);
  assign full_wr         = (wr_ptr == {~rd_ptr[log_depth], rd_ptr[log_depth-1:0]});
  assign almost_empty_rd = (fill == {{log_depth{1'b0}}, 1'b1});
  assign data_rd         = mem[rd_ptr[log_depth-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is reset on purpose so data_rd reads 0 after
  // reset; this forces flops rather than a RAM macro for the storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr[log_depth-1:0]] <= data_wr;
    end
  end

endmodule

// File: tb/tb_resync_fifo_nonsynt.sv
// Self-checking bench for resync_fifo_nonsynt: directed scenarios plus a
// random phase, compared against a queue-based occupancy model.
module tb_resync_fifo_nonsynt;

  localparam int WIDTH = 20;
  localparam int LOG   = 3;
  localparam int DEPTH = 2 ** LOG;

  logic             clk;
  logic             rst_n;
  logic             val_wr;
  logic [WIDTH-1:0] data_wr;
  logic             val_rd;
  logic [WIDTH-1:0] data_rd;
  logic             empty_rd;
  logic             full_wr;
  logic             almost_empty_rd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] model_q [$];

  resync_fifo_nonsynt #(.width(WIDTH), .log_depth(LOG)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .val_wr          (val_wr),
    .data_wr         (data_wr),
    .val_rd          (val_rd),
    .data_rd         (data_rd),
    .empty_rd        (empty_rd),
    .full_wr         (full_wr),
    .almost_empty_rd (almost_empty_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model; head data only matters when non-empty.
  task automatic check_outputs(input string tag);
    check({tag, ".empty"},  {31'd0, empty_rd},        {31'd0, model_q.size() == 0});
    check({tag, ".full"},   {31'd0, full_wr},         {31'd0, model_q.size() == DEPTH});
    check({tag, ".almost"}, {31'd0, almost_empty_rd}, {31'd0, model_q.size() == 1});
    if (model_q.size() != 0)
      check({tag, ".data"}, 32'(data_rd), 32'(model_q[0]));
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge,
  // then sample outputs at the next falling edge.
  task automatic cycle(input string tag, input logic w, input logic [WIDTH-1:0] d, input logic r);
    bit acc_w;
    bit acc_r;
    val_wr  = w;
    data_wr = d;
    val_rd  = r;
    acc_w = w && (model_q.size() < DEPTH);
    acc_r = r && (model_q.size() > 0);
    @(posedge clk);
    if (acc_r) void'(model_q.pop_front());
    if (acc_w) model_q.push_back(d);
    @(negedge clk);
    val_wr = 1'b0;
    val_rd = 1'b0;
    check_outputs(tag);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
  endtask

  initial begin
    logic [WIDTH-1:0] rd;
    rst_n   = 1'b0;
    val_wr  = 1'b0;
    val_rd  = 1'b0;
    data_wr = '0;

    // Reset state
    apply_reset();
    check_outputs("reset");
    check("reset.data_zero", 32'(data_rd), 32'h0);

    // Single word: accepted on the first edge after reset release
    cycle("single_wr", 1'b1, 20'h12345, 1'b0);
    check("single.data", 32'(data_rd), 32'h12345);
    check("single.almost", {31'd0, almost_empty_rd}, 32'd1);
    cycle("single_pop", 1'b0, '0, 1'b1);
    check("single.empty_after_pop", {31'd0, empty_rd}, 32'd1);
    cycle("pop_on_empty", 1'b0, '0, 1'b1);

    // Fill to DEPTH, ignored extra write, drain in order
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, WIDTH'(i), 1'b0);
    check("fill.full", {31'd0, full_wr}, 32'd1);
    cycle("fill.overflow", 1'b1, 20'hFFFFF, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.order", 32'(data_rd), 32'(i));
      cycle("drain", 1'b0, '0, 1'b1);
    end
    check("drain.empty", {31'd0, empty_rd}, 32'd1);

    // Simultaneous read/write with 4 held, crossing pointer wrap
    for (int i = 0; i < 4; i++) cycle("simul_pre", 1'b1, 20'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) cycle("simul", 1'b1, 20'($urandom), 1'b1);
    while (model_q.size() > 0) cycle("simul_drain", 1'b0, '0, 1'b1);

    // Full with both requests: pop happens, write dropped
    for (int i = 0; i < DEPTH; i++) cycle("full_pre", 1'b1, WIDTH'(16'hA000 + i), 1'b0);
    check("fullsim.full_before", {31'd0, full_wr}, 32'd1);
    cycle("fullsim", 1'b1, 20'hBEEF0, 1'b1);
    check("fullsim.not_full", {31'd0, full_wr}, 32'd0);
    check("fullsim.head", 32'(data_rd), 32'hA001);
    while (model_q.size() > 0) cycle("fullsim_drain", 1'b0, '0, 1'b1);

    // Reset mid-stream: 5 entries held, rst_n pulsed between edges
    for (int i = 0; i < 5; i++) cycle("mid_pre", 1'b1, WIDTH'(20'h5_0000 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.empty_now", {31'd0, empty_rd}, 32'd1);
    check("midrst.data_zero", 32'(data_rd), 32'h0);
    check("midrst.full_now", {31'd0, full_wr}, 32'd0);
    #1 rst_n = 1'b1;
    model_q.delete();
    @(negedge clk);
    check_outputs("midrst.after");
    cycle("midrst.newwr", 1'b1, 20'h0ABCD, 1'b0);
    cycle("midrst.pop", 1'b0, '0, 1'b1);
    check("midrst.no_old", {31'd0, empty_rd}, 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rd = 20'($urandom);
      cycle("random", ($urandom_range(0, 99) < 55), rd, ($urandom_range(0, 99) < 45));
    end
    while (model_q.size() > 0) cycle("random_drain", 1'b0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/resync_fifo_nonsynt.md
RESYNC_FIFO_NONSYNT -- requirements
Module: resync_fifo_nonsynt

Interface
REQ-001 The module SHALL have parameter width, default 20, giving the data word width in bits.
REQ-002 The module SHALL have parameter log_depth, default 3, giving FIFO depth DEPTH = 2**log_depth entries.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port val_wr, input, 1 bit: write request.
REQ-006 The module SHALL have port data_wr, input, width bits: write data.
REQ-007 The module SHALL have port val_rd, input, 1 bit: read/pop request.
REQ-008 The module SHALL have port data_rd, output, width bits: head-of-FIFO data, first-word-fall-through.
REQ-009 The module SHALL have port empty_rd, output, 1 bit: FIFO holds 0 entries.
REQ-010 The module SHALL have port full_wr, output, 1 bit: FIFO holds DEPTH entries.
REQ-011 The module SHALL have port almost_empty_rd, output, 1 bit: FIFO holds exactly 1 entry.

Function
REQ-012 Storage SHALL be DEPTH x width words, addressed by write and read pointers of log_depth+1 bits; the MSB is the wrap bit.
REQ-013 A write SHALL occur on a rising clk edge when val_wr=1 and full_wr=0: data_wr is stored at wr_ptr and wr_ptr increments modulo 2**(log_depth+1).
REQ-014 val_wr=1 while full_wr=1 SHALL be ignored: no storage change, no pointer change, no overwrite.
REQ-015 A read SHALL occur on a rising clk edge when val_rd=1 and empty_rd=0: rd_ptr increments.
REQ-016 val_rd=1 while empty_rd=1 SHALL be ignored; rd_ptr never passes wr_ptr.
REQ-017 data_rd SHALL combinationally equal mem[rd_ptr]; a written word SHALL appear on data_rd in the cycle after the write, when the FIFO was empty.
REQ-018 While the FIFO is empty, data_rd SHALL show the last-read or reset contents and is don't-care to consumers.
REQ-019 Simultaneous accepted read and write in one cycle SHALL both take effect; occupancy is unchanged.
REQ-020 Accept decisions SHALL use registered flag state only; full with val_rd=1 and val_wr=1 SHALL pop but not write.
REQ-021 Flags SHALL be derived combinationally from the pointers.
REQ-022 empty_rd SHALL be set when wr_ptr == rd_ptr.
REQ-023 full_wr SHALL be set when the pointers differ only in the MSB.
REQ-024 almost_empty_rd SHALL be set when wr_ptr - rd_ptr == 1.
REQ-025 Occupancy SHALL range 0..DEPTH, and pointer wrap-around SHALL be transparent.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear wr_ptr, rd_ptr and all storage words to 0, giving empty_rd=1, full_wr=0, almost_empty_rd=0 and data_rd=0.
REQ-027 Reset asserted mid-operation SHALL discard all contents immediately.
REQ-028 The first write SHALL be accepted on the first rising clk edge after rst_n deasserts.

Structure
REQ-029 The FIFO SHALL be a single flat module with no sub-modules; DEPTH SHALL be a local constant, and no shared package is needed.
REQ-030 The design SHALL be synthesizable and SHALL contain no simulation-only constructs.

Verification
REQ-031 Reset test: after reset, expect empty_rd=1, full_wr=0, almost_empty_rd=0, data_rd=0.
REQ-032 Single-word test: write 0x12345, then next cycle expect data_rd=0x12345, empty_rd=0, almost_empty_rd=1; a pop then sets empty_rd=1.
REQ-033 Fill test: write 8 words 0..7 with log_depth=3, expect full_wr=1; a 9th write is ignored, and 8 pops return 0..7 in order.
REQ-034 Simultaneous test: with 4 entries held, val_wr=val_rd=1 for 20 cycles keeps occupancy at 4 with data in order across pointer wrap.
REQ-035 Full-simultaneous test: when full, val_wr=val_rd=1 pops one entry, the write is dropped, and full_wr=0 next cycle.
REQ-036 Reset mid-stream test: with 5 entries held, pulse rst_n low between clk edges; empty_rd=1 immediately and prior data is never read.
